// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data load/store with timeout protection
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int STARVE_LIMIT   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_done,
    output logic [31:0] fetch_data,
    input  logic        data_req,
    input  logic        data_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_done,
    output logic [31:0] data_rdata,
    output logic        access_err,
    output logic        busy,
    output logic        owner,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic [1:0]  mem_r_w_z_z,
    input  logic [31:0] mem_data_out,
    input  logic        mem_mfc,
    input  logic        mem_error
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_n;
    logic [7:0] tcnt, scnt;
    logic is_write, err, both, grant_data, timeout, fail, finish;
    // arbitration, access outcome and next state
    always_comb begin
        both       = fetch_req & data_req;
        grant_data = data_req & !(both & (scnt == 8'(STARVE_LIMIT)));
        timeout    = tcnt == 8'(TIMEOUT_CYCLES - 1);
        fail       = mem_error | (!mem_mfc & timeout);
        finish     = mem_error | mem_mfc | timeout;
        state_n    = state == IDLE   ? ((fetch_req | data_req) ? ACCESS : IDLE) :
                     state == ACCESS ? (finish ? RESP : ACCESS) : IDLE;
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end
    // grant capture, counters and read data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner       <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
            is_write    <= 1'b0;
            err         <= 1'b0;
            tcnt        <= '0;
            scnt        <= '0;
            fetch_data  <= '0;
            data_rdata  <= '0;
        end else begin
            if (state == IDLE && (fetch_req | data_req)) begin
                owner       <= grant_data;
                mem_address <= grant_data ? data_addr : fetch_addr;
                mem_data_in <= data_wdata;
                is_write    <= grant_data & data_write;
                scnt        <= (both && grant_data) ? scnt + 8'd1 : 8'd0;
            end
            if (state == ACCESS) begin
                tcnt <= tcnt + 8'd1;
                if (finish) begin
                    err <= fail;
                    if (owner) data_rdata <= fail ? 32'd0 : (is_write ? data_rdata : mem_data_out);
                    else       fetch_data <= fail ? 32'd0 : mem_data_out;
                end
            end
            if (state == RESP) tcnt <= '0;
        end
    end
    assign busy        = state != IDLE;
    assign fetch_done  = (state == RESP) & !owner;
    assign data_done   = (state == RESP) & owner;
    assign access_err  = (state == RESP) & err;
    assign mem_r_w_z_z = state == ACCESS ? {1'b0, is_write} : 2'b10;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant, timeout, error and reset behaviour
module tb_mem_port_arbiter;
    logic clk = 1'b0, rst_n = 1'b0;
    logic fetch_req = 1'b0, data_req = 1'b0, data_write = 1'b0, mem_mfc = 1'b0, mem_error = 1'b0;
    logic [31:0] fetch_addr = '0, data_addr = '0, data_wdata = '0, mem_data_out = '0;
    logic fetch_done, data_done, access_err, busy, owner;
    logic [31:0] fetch_data, data_rdata, mem_address, mem_data_in;
    logic [1:0] mem_r_w_z_z;
    int checks = 0, errors = 0;

    mem_port_arbiter #(.TIMEOUT_CYCLES(15), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_done(fetch_done), .fetch_data(fetch_data),
        .data_req(data_req), .data_write(data_write), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_done(data_done), .data_rdata(data_rdata), .access_err(access_err), .busy(busy), .owner(owner),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_r_w_z_z(mem_r_w_z_z),
        .mem_data_out(mem_data_out), .mem_mfc(mem_mfc), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    logic exp_owner [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        #2;
        chk("rst_rwzz", 32'(mem_r_w_z_z), 32'd2);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_done", 32'({fetch_done, data_done, access_err}), 32'd0);
        chk("rst_addr", mem_address, 32'd0);
        chk("rst_din", mem_data_in, 32'd0);
        chk("rst_fdata", fetch_data, 32'd0);
        chk("rst_rdata", data_rdata, 32'd0);
        nxt();
        rst_n = 1'b1;
        nxt();
        chk("idle_busy", 32'(busy), 32'd0);
        // single fetch, MFC in the first ACCESS cycle
        fetch_req = 1'b1; fetch_addr = 32'h10;
        nxt();
        chk("f_rwzz", 32'(mem_r_w_z_z), 32'd0);
        chk("f_addr", mem_address, 32'h10);
        chk("f_busy", 32'(busy), 32'd1);
        chk("f_owner", 32'(owner), 32'd0);
        fetch_req = 1'b0; mem_mfc = 1'b1; mem_data_out = 32'hDEADBEEF;
        nxt();
        chk("f_done", 32'({fetch_done, data_done}), 32'b10);
        chk("f_data", fetch_data, 32'hDEADBEEF);
        chk("f_err", 32'(access_err), 32'd0);
        chk("f_resp_rwzz", 32'(mem_r_w_z_z), 32'd2);
        mem_mfc = 1'b0;
        nxt();
        chk("f_idle", 32'({busy, fetch_done}), 32'd0);
        chk("f_hold", fetch_data, 32'hDEADBEEF);
        // store with MFC in the third ACCESS cycle; request dropped mid-access
        data_req = 1'b1; data_write = 1'b1; data_addr = 32'h20; data_wdata = 32'h12345678;
        nxt();
        chk("w_owner", 32'(owner), 32'd1);
        chk("w_addr", mem_address, 32'h20);
        data_req = 1'b0; data_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) nxt();
            chk("w_rwzz", 32'(mem_r_w_z_z), 32'd1);
            chk("w_din", mem_data_in, 32'h12345678);
            chk("w_nodone", 32'(data_done), 32'd0);
        end
        mem_mfc = 1'b1;
        nxt();
        chk("w_done", 32'({fetch_done, data_done, access_err}), 32'b010);
        chk("w_rdata", data_rdata, 32'd0);
        mem_mfc = 1'b0;
        nxt();
        chk("w_idle", 32'(data_done), 32'd0);
        // both requests held: data wins three times, then fetch once
        fetch_req = 1'b1; data_req = 1'b1; data_write = 1'b0; fetch_addr = 32'h44; data_addr = 32'h88;
        mem_mfc = 1'b1; mem_data_out = 32'hCAFEF00D;
        for (int i = 0; i < 5; i++) begin
            nxt();
            chk("s_owner", 32'(owner), 32'(exp_owner[i]));
            chk("s_addr", mem_address, exp_owner[i] ? 32'h88 : 32'h44);
            nxt();
            chk("s_done", 32'({fetch_done, data_done}), exp_owner[i] ? 32'b01 : 32'b10);
            nxt();
        end
        chk("s_fdata", fetch_data, 32'hCAFEF00D);
        chk("s_rdata", data_rdata, 32'hCAFEF00D);
        fetch_req = 1'b0; data_req = 1'b0; mem_mfc = 1'b0;
        // read with no MFC: times out after 15 ACCESS cycles
        nxt();
        data_req = 1'b1; data_addr = 32'h30;
        for (int i = 0; i < 15; i++) begin
            nxt();
            data_req = 1'b0;
            chk("t_access", 32'({busy, mem_r_w_z_z, data_done}), 32'b1000);
        end
        nxt();
        chk("t_done", 32'({data_done, access_err}), 32'b11);
        chk("t_rdata", data_rdata, 32'd0);
        chk("t_rwzz", 32'(mem_r_w_z_z), 32'd2);
        nxt();
        chk("t_idle", 32'({busy, access_err}), 32'd0);
        // MEM_ERROR together with MFC on a fetch
        fetch_req = 1'b1; fetch_addr = 32'h40;
        nxt();
        fetch_req = 1'b0; mem_mfc = 1'b1; mem_error = 1'b1; mem_data_out = 32'h11111111;
        nxt();
        chk("e_done", 32'({fetch_done, access_err}), 32'b11);
        chk("e_fdata", fetch_data, 32'd0);
        mem_mfc = 1'b0; mem_error = 1'b0;
        nxt();
        chk("e_idle", 32'(access_err), 32'd0);
        // reset in the second ACCESS cycle
        data_req = 1'b1; data_write = 1'b1; data_addr = 32'h50;
        nxt();
        data_req = 1'b0;
        nxt();
        chk("r_rwzz_pre", 32'(mem_r_w_z_z), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("r_rwzz", 32'(mem_r_w_z_z), 32'd2);
        chk("r_busy", 32'(busy), 32'd0);
        nxt();
        chk("r_nodone", 32'({fetch_done, data_done}), 32'd0);
        rst_n = 1'b1;
        nxt();
        chk("r_after", 32'({busy, fetch_done, data_done}), 32'd0);
        chk("r_addr", mem_address, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
